product_serializer: RTL

PRODUCT_SERIALIZER -- requirements
Module: product_serializer

---
 rtl/product_serializer_if.sv | 26 ++
 rtl/product_serializer.sv | 101 ++++++++++
 2 files changed

// File: rtl/product_serializer_if.sv
// Handshake bundle for the product serializer: a parallel-word input stream
// and a half-word output stream, each with valid/ready flow control.
interface product_serializer_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N/2-1:0] out_data;
  logic           out_hi;
  logic           out_last;

  // Serializer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_hi, out_last
  );

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_hi, out_last
  );
endinterface

// File: rtl/product_serializer.sv
// Splits each accepted N-bit word into two N/2-bit beats (order set by
// HIGH_FIRST) and counts fully emitted words modulo 256.
module product_serializer #(
  parameter int N          = 16,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                clear,
  product_serializer_if.slave bus,
  output logic [7:0]          word_count
);
  localparam int H = N / 2;

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   word_q, word_d;
  logic [7:0]     count_q, count_d;

  logic           in_ready;
  logic           out_valid;
  logic [H-1:0]   out_data;
  logic           out_hi;
  logic           out_last;

  logic [H-1:0]   upper_half;
  logic [H-1:0]   lower_half;

  assign upper_half = word_q[N-1:H];
  assign lower_half = word_q[H-1:0];

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_hi    = 1'b0;
    out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          state_d = FIRST;
        end
      end
      FIRST: begin
        out_valid = 1'b1;
        out_hi    = HIGH_FIRST;
        out_data  = HIGH_FIRST ? upper_half : lower_half;
        if (bus.out_ready) begin
          state_d = SECOND;
        end
      end
      SECOND: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_hi    = !HIGH_FIRST;
        out_data  = HIGH_FIRST ? lower_half : upper_half;
        // A new word may only enter when the current one is leaving,
        // which lets back-to-back words stream without a bubble.
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          count_d = count_q + 8'd1;
          if (bus.in_valid) begin
            word_d  = bus.in_data;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_hi    = out_hi;
  assign bus.out_last  = out_last;
  assign word_count    = count_q;

endmodule
